// File: rtl/wts_mixer_pkg.sv
// wts_mixer_pkg
// Shared widths and constants for the wave-table channel mixer.
//   WAVE_W    : signed wave-table sample width
//   LEVEL_W   : envelope level width (0 = silent, LEVEL_MAX = full scale)
//   PROD_W    : stage-1 product width (wave x clamped level)
//   ACC_W     : frame accumulator width
//   VOL_W     : master volume width
//   VOL_SHIFT : right shift applied after the master-volume multiply
package wts_mixer_pkg;
  localparam int WAVE_W    = 8;
  localparam int LEVEL_W   = 7;
  localparam int LEVEL_MAX = 64;
  localparam int PROD_W    = 15;
  localparam int ACC_W     = 18;
  localparam int VOL_W     = 4;
  localparam int VOL_SHIFT = 4;
  // acc x {0,vol} never overflows this width.
  localparam int MIX_W     = ACC_W + VOL_W + 1;
endpackage

// File: rtl/wts_channel_mixer_if.sv
// wts_channel_mixer_if
// Per-slot channel stream into the mixer.
//   ch_valid : a channel slot is presented this cycle
//   ch_first : first channel of a frame (qualified by ch_valid)
//   ch_last  : last channel of a frame (qualified by ch_valid)
//   ch_wave  : signed wave-table sample
//   ch_level : envelope level, 0..64 meaningful, larger values clamp
//   ch_mute  : channel contributes zero
interface wts_channel_mixer_if;
  import wts_mixer_pkg::*;

  logic               ch_valid;
  logic               ch_first;
  logic               ch_last;
  logic [WAVE_W-1:0]  ch_wave;
  logic [LEVEL_W-1:0] ch_level;
  logic               ch_mute;

  modport master (
    output ch_valid, ch_first, ch_last, ch_wave, ch_level, ch_mute
  );

  modport slave (
    input ch_valid, ch_first, ch_last, ch_wave, ch_level, ch_mute
  );
endinterface

// File: rtl/wts_mixer_mul.sv
// wts_mixer_mul
// Combinational stage-1 multiply: signed wave x clamped unsigned level,
// forced to zero when muted.
//   wave  : signed wave-table sample
//   level : envelope level; values above LEVEL_MAX are treated as LEVEL_MAX
//   mute  : force the product to zero
//   prod  : signed product, range -8192..+8128
module wts_mixer_mul
  import wts_mixer_pkg::*;
(
  input  logic signed [WAVE_W-1:0]  wave,
  input  logic        [LEVEL_W-1:0] level,
  input  logic                      mute,
  output logic signed [PROD_W-1:0]  prod
);

  logic [LEVEL_W-1:0]       eff_level;
  logic signed [PROD_W-1:0] wave_ext;
  logic signed [PROD_W-1:0] level_ext;

  assign eff_level = (level > LEVEL_W'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX) : level;

  // The true product always fits in PROD_W bits, so multiplying at that
  // width loses nothing.
  assign wave_ext  = PROD_W'(wave);
  assign level_ext = $signed(PROD_W'(eff_level));
  assign prod      = mute ? '0 : (wave_ext * level_ext);

endmodule

// File: rtl/wts_channel_mixer.sv
// wts_channel_mixer
// Sums scaled wave-table channels over a frame of slots, applies a master
// volume and emits one saturated sample per frame.
//   clk            : system clock, rising edge
//   nreset         : asynchronous active-low reset
//   ch             : channel slot stream (slave modport)
//   reg_master_vol : master volume 0..15, sampled when the output is formed
//   sample_out     : signed mixed sample, held between updates
//   sample_valid   : one-cycle pulse when sample_out updates
// Latency: ch_last slot at cycle N -> sample_valid at cycle N+3.
module wts_channel_mixer
  import wts_mixer_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    nreset,
  wts_channel_mixer_if.slave      ch,
  input  logic [VOL_W-1:0]        reg_master_vol,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid
);

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (OUT_W - 1));

  // Stage 1: registered product plus frame flags.
  logic signed [PROD_W-1:0] mul_prod;
  logic signed [PROD_W-1:0] s1_prod;
  logic                     s1_valid;
  logic                     s1_first;
  logic                     s1_last;

  // Stage 2: accumulator and a flag saying it now holds a finished frame.
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     s2_last;

  logic signed [MIX_W-1:0]  mix_prod;
  logic signed [MIX_W-1:0]  mix;
  logic signed [63:0]       mix_wide;
  logic signed [OUT_W-1:0]  sat_mix;

  wts_mixer_mul u_mul (
    .wave  (ch.ch_wave),
    .level (ch.ch_level),
    .mute  (ch.ch_mute),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else begin
      s1_valid <= ch.ch_valid;
      // Flags and product only matter with ch_valid; clearing them on idle
      // slots keeps stage 2 from seeing stale flags.
      s1_first <= ch.ch_valid & ch.ch_first;
      s1_last  <= ch.ch_valid & ch.ch_last;
      s1_prod  <= ch.ch_valid ? mul_prod : '0;
    end
  end

  // A slot without ch_first simply keeps adding to whatever is there.
  assign acc_next = s1_first ? ACC_W'(s1_prod) : (acc + ACC_W'(s1_prod));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc     <= '0;
      s2_last <= 1'b0;
    end else begin
      if (s1_valid) begin
        acc <= acc_next;
      end
      s2_last <= s1_valid & s1_last;
    end
  end

  // acc is the finished frame's sum whenever s2_last is set; a following
  // frame's first slot only overwrites acc one cycle later.
  assign mix_prod = MIX_W'(acc) * $signed(MIX_W'(reg_master_vol));
  assign mix      = mix_prod >>> VOL_SHIFT;
  assign mix_wide = 64'(mix);

  always_comb begin
    sat_mix = mix_wide[OUT_W-1:0];
    if (mix_wide > SAT_MAX) begin
      sat_mix = SAT_MAX[OUT_W-1:0];
    end else if (mix_wide < SAT_MIN) begin
      sat_mix = SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= s2_last;
      if (s2_last) begin
        sample_out <= sat_mix;
      end
    end
  end

endmodule

// File: tb/tb_wts_channel_mixer.sv
// tb_wts_channel_mixer
// Directed bench: a behavioural model predicts each frame's output when
// the last slot is driven and pushes it to a scoreboard; a monitor pops and
// compares value and arrival cycle whenever sample_valid pulses.
module tb_wts_channel_mixer;

  localparam int OUT_W = 16;

  typedef struct {
    int    value;
    int    cyc;
    string tag;
  } exp_t;

  logic              clk;
  logic              nreset;
  logic [3:0]        vol;
  logic signed [OUT_W-1:0] sample_out;
  logic              sample_valid;

  int   vectors;
  int   miscompares;
  int   cyc;
  exp_t sb[$];

  // Behavioural model state.
  longint model_acc;

  wts_channel_mixer_if ch_if();

  wts_channel_mixer #(.OUT_W(OUT_W)) dut (
    .clk            (clk),
    .nreset         (nreset),
    .ch             (ch_if),
    .reg_master_vol (vol),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (nreset === 1'b1 && sample_valid === 1'b1) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_valid observed=%0d expected=no output at cycle %0d",
               int'(sample_out), cyc);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        vectors++;
        assert (int'(sample_out) === e.value) else begin
          miscompares++;
          $error("FAIL %s_value observed=%0d expected=%0d", e.tag, int'(sample_out), e.value);
        end
        vectors++;
        assert (cyc === e.cyc) else begin
          miscompares++;
          $error("FAIL %s_latency observed_cycle=%0d expected_cycle=%0d", e.tag, cyc, e.cyc);
        end
        $display("out %-10s sample_out=%0d cycle=%0d", e.tag, int'(sample_out), cyc);
      end
    end
  end

  function automatic int sat(input longint v);
    longint mx, mn;
    mx = (64'sd1 <<< (OUT_W - 1)) - 1;
    mn = -(64'sd1 <<< (OUT_W - 1));
    if (v > mx) return int'(mx);
    if (v < mn) return int'(mn);
    return int'(v);
  endfunction

  // Drive one valid slot and update the model.
  task automatic slot(input string tag, input bit first, input bit last,
                      input int wave, input int level, input bit mute);
    longint prod;
    longint mix;
    exp_t   e;
    @(posedge clk);
    #1;
    ch_if.ch_valid = 1'b1;
    ch_if.ch_first = first;
    ch_if.ch_last  = last;
    ch_if.ch_wave  = 8'(wave);
    ch_if.ch_level = 7'(level);
    ch_if.ch_mute  = mute;
    prod = mute ? 0 : longint'(wave) * longint'((level > 64) ? 64 : level);
    model_acc = first ? prod : model_acc + prod;
    $display("slot %-10s first=%0b last=%0b wave=%0d level=%0d mute=%0b model_acc=%0d",
             tag, first, last, wave, level, mute, model_acc);
    if (last) begin
      mix = (model_acc * longint'(vol)) >>> 4;
      e.value = sat(mix);
      e.cyc   = cyc + 3;
      e.tag   = tag;
      sb.push_back(e);
    end
  endtask

  // Idle cycles with random junk on the qualified fields.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ch_if.ch_valid = 1'b0;
      ch_if.ch_first = 1'($urandom);
      ch_if.ch_last  = 1'($urandom);
      ch_if.ch_wave  = 8'($urandom);
      ch_if.ch_level = 7'($urandom);
      ch_if.ch_mute  = 1'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    assert (sample_out === '0) else begin
      miscompares++;
      $error("FAIL %s_sample_out observed=%0d expected=0", tag, int'(sample_out));
    end
    vectors++;
    assert (sample_valid === 1'b0) else begin
      miscompares++;
      $error("FAIL %s_sample_valid observed=%0b expected=0", tag, sample_valid);
    end
    $display("rst  %-10s sample_out=%0d sample_valid=%0b", tag, int'(sample_out), sample_valid);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_acc   = 0;
    nreset      = 1'b0;
    vol         = 4'd15;
    ch_if.ch_valid = 1'b0;
    ch_if.ch_first = 1'b0;
    ch_if.ch_last  = 1'b0;
    ch_if.ch_wave  = '0;
    ch_if.ch_level = '0;
    ch_if.ch_mute  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    nreset = 1'b1;
    idle(2);

    // Full-scale positive frame saturates high.
    vol = 4'd15;
    for (int i = 0; i < 5; i++) slot("sat_pos", i == 0, i == 4, 127, 64, 1'b0);
    idle(6);

    // Full-scale negative frame saturates low.
    for (int i = 0; i < 5; i++) slot("sat_neg", i == 0, i == 4, -128, 64, 1'b0);
    idle(6);

    // Single-slot frame with clamped level.
    vol = 4'd8;
    slot("single", 1'b1, 1'b1, -3, 100, 1'b0);
    idle(6);

    // Muted middle slot, then a back-to-back frame.
    vol = 4'd15;
    slot("mute3", 1'b1, 1'b0, 10, 32, 1'b0);
    slot("mute3", 1'b0, 1'b0, 10, 32, 1'b1);
    slot("mute3", 1'b0, 1'b1, 10, 32, 1'b0);
    slot("b2b", 1'b1, 1'b0, -20, 50, 1'b0);
    slot("b2b", 1'b0, 1'b1, 7, 127, 1'b0);
    idle(6);

    // Slots separated by idle gaps.
    vol = 4'd4;
    slot("gaps", 1'b1, 1'b0, 50, 64, 1'b0);
    idle(3);
    slot("gaps", 1'b0, 1'b1, 50, 64, 1'b0);
    idle(6);

    // Zero master volume.
    vol = 4'd0;
    slot("vol0", 1'b1, 1'b0, 100, 64, 1'b0);
    slot("vol0", 1'b0, 1'b1, 90, 40, 1'b0);
    idle(6);

    // Frame without ch_first continues from the previous accumulator.
    vol = 4'd3;
    slot("nofirst", 1'b0, 1'b0, -7, 20, 1'b0);
    slot("nofirst", 1'b0, 1'b1, 33, 5, 1'b0);
    idle(6);

    // Reset in the middle of a frame discards it.
    vol = 4'd15;
    slot("trunc", 1'b1, 1'b0, 120, 64, 1'b0);
    slot("trunc", 1'b0, 1'b0, 120, 64, 1'b0);
    @(posedge clk);
    #1;
    ch_if.ch_valid = 1'b0;
    nreset = 1'b0;
    model_acc = 0;
    #2;
    check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst2");
    @(posedge clk);
    #1;
    nreset = 1'b1;
    idle(4);
    for (int i = 0; i < 5; i++) slot("postrst", i == 0, i == 4, 3 + i, 10 * i, 1'b0);
    idle(6);

    // A few random frames.
    for (int f = 0; f < 6; f++) begin
      int n;
      n = int'($urandom_range(1, 5));
      vol = 4'($urandom);
      for (int i = 0; i < n; i++) begin
        slot("rand", i == 0, i == n - 1, int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 127)), bit'($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(5);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL drain observed_pending=%0d expected_pending=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wts_channel_mixer.md
WTS_CHANNEL_MIXER -- requirements
Module: wts_channel_mixer

Interface
REQ-001 SHALL have parameter OUT_W, default 16, meaning width of the signed output sample.
REQ-002 SHALL have: clk  input  1  single system clock; all state is updated on its rising edge.
REQ-003 SHALL have: nreset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have: ch_valid  input  1  a channel slot is presented this cycle.
REQ-005 SHALL have: ch_first  input  1  the slot is the first channel of a frame; qualified by ch_valid.
REQ-006 SHALL have: ch_last  input  1  the slot is the last channel of a frame; qualified by ch_valid.
REQ-007 SHALL have: ch_wave  input  8  signed two's-complement wave-table sample.
REQ-008 SHALL have: ch_level  input  7  envelope level, where 0 is silent and 64 is full scale.
REQ-009 SHALL have: ch_mute  input  1  the channel contributes zero.
REQ-010 SHALL have: reg_master_vol  input  4  master volume 0..15, sampled when the output is formed.
REQ-011 SHALL have: sample_out  output  OUT_W  signed mixed sample, held between updates.
REQ-012 SHALL have: sample_valid  output  1  one-cycle pulse when sample_out updates.

Function
REQ-013 SHALL clamp ch_level values 65..127 to 64 before multiplication.
REQ-014 SHALL form a stage-1 product = ch_wave (signed) x effective level, 15-bit signed (range -8192..+8128), or 0 when ch_mute=1.
REQ-015 SHALL register the stage-1 product, together with the first and last flags and a valid bit, one cycle after a ch_valid cycle; product register latency is 1.
REQ-016 SHALL hold an 18-bit signed accumulator, updated in the cycle after a stage-1 valid (cycle N+2 for input at cycle N): acc = product if first, else acc + product.
REQ-017 SHALL leave acc unchanged in cycles without a stage-1 valid, so gaps between slots are allowed.
REQ-018 SHALL continue accumulating onto the previous value if a frame starts without ch_first; no error is flagged.
REQ-019 SHALL, when the stage-2 slot is last, form mix = (new acc value x reg_master_vol) arithmetic-shifted right by 4, computed at full width without intermediate overflow.
REQ-020 SHALL saturate mix to [-2^(OUT_W-1), 2^(OUT_W-1)-1], register it into sample_out, and pulse sample_valid at cycle N+3 relative to the ch_last input at cycle N.
REQ-021 SHALL treat ch_first=ch_last=1 in one slot as a single-channel frame, with output equal to that channel's scaled product.
REQ-022 SHALL allow back-to-back frames: a ch_first slot at cycle N+1 after a ch_last slot at cycle N does not corrupt the completed frame's output.
REQ-023 SHALL produce sample_out=0 and sample_valid pulsed when reg_master_vol=0 at output formation.
REQ-024 SHALL ignore ch_first, ch_last, ch_wave, ch_level and ch_mute when ch_valid=0.

Reset
REQ-025 SHALL, on nreset low, asynchronously clear the stage-1 registers, the accumulator, sample_out (0) and sample_valid (0).
REQ-026 SHALL discard any partial frame in flight when reset is asserted mid-frame; the first output after reset release comes from a frame that ends after release.

Structure
REQ-027 SHALL take its widths from shared package wts_mixer_pkg: WAVE_W=8, LEVEL_W=7, LEVEL_MAX=64, PROD_W=15, ACC_W=18, VOL_W=4, VOL_SHIFT=4.
REQ-028 SHALL implement the level clamp and mute-gated signed x unsigned multiply in sub-module wts_mixer_mul (combinational); pipeline registers stay in wts_channel_mixer.

Verification
REQ-029 SHALL cover: 5-slot frame, each wave=+127, level=64, vol=15 -> acc=40640 -> mix 38100 -> sample_out=+32767 (saturated), valid at last+3.
REQ-030 SHALL cover: 5 slots wave=-128, level=64, vol=15 -> acc=-40960 -> sample_out=-32768.
REQ-031 SHALL cover: single slot first=last=1, wave=-3, level=100, vol=8 -> level clamped 64 -> product -192 -> mix -96 -> sample_out=-96.
REQ-032 SHALL cover: 3-slot frame wave=10, level=32, slot 2 muted, vol=16-shift-neutral check with vol=15 -> acc=640 -> sample_out=600; a next frame starting the following cycle gives an independent result.
REQ-033 SHALL cover: nreset pulsed after the 2nd slot of a 5-slot frame -> no sample_valid from the truncated frame; all outputs read 0 during reset.
REQ-034 SHALL cover: slots separated by 3 idle cycles each, 2 slots wave=50 level=64, vol=4 -> acc=6400 -> sample_out=1600.
